// File: rtl/xc_aessub.sv
// xc_aessub: AES SubBytes / InvSubBytes instruction unit.
// FAST=1: four S-boxes in one cycle; FAST=0: one shared S-box over four cycles.
module xc_aessub #(
    parameter bit FAST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_data,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {ST0, ST1, ST2, ST3} state_t;

    state_t          fsm;
    logic [7:0]      r0, r1, r2;
    logic [3:0][7:0] bytes_in;

    assign bytes_in = {rs2[31:16], rs1[15:0]};

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 equals a^-1 for a!=0 and yields 0 for a==0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]}
                 ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]}
             ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic fwd);
        logic [7:0] t;
        t = fwd ? x : aff_inv(x);
        t = gf_inv(t);
        return fwd ? aff_fwd(t) : t;
    endfunction

    if (FAST) begin : g_fast
        logic [31:0] sub;
        logic        unused_fast;

        // four parallel substitutions, inputs gated by valid
        always_comb begin
            sub = '0;
            for (int i = 0; i < 4; i++) begin
                sub[8*i +: 8] = sbox(bytes_in[i] & {8{valid}}, enc);
            end
        end

        assign ready  = valid;
        assign result = valid ? sub : 32'h0;
        assign fsm    = ST0;
        assign r0     = 8'h00;
        assign r1     = 8'h00;
        assign r2     = 8'h00;
        assign unused_fast = ^{clock, reset, flush, flush_data,
                               fsm, r0, r1, r2};
    end else begin : g_slow
        state_t     fsm_nx;
        logic [7:0] r0_nx, r1_nx, r2_nx;
        logic [7:0] step_in, step_out;
        logic       unused_flush_hi;

        assign step_in  = bytes_in[fsm] & {8{valid}};
        assign step_out = sbox(step_in, enc);
        assign ready    = (fsm == ST3);
        assign result   = ready ? {step_out, r2, r1, r0} : 32'h0;
        assign unused_flush_hi = ^flush_data[31:24];

        // sequence through the four bytes; flush overrides capture
        always_comb begin
            fsm_nx = fsm;
            r0_nx  = r0;
            r1_nx  = r1;
            r2_nx  = r2;
            if (flush) begin
                fsm_nx = ST0;
                {r2_nx, r1_nx, r0_nx} = flush_data[23:0];
            end else begin
                unique case (fsm)
                    ST0: if (valid) begin
                        r0_nx  = step_out;
                        fsm_nx = ST1;
                    end
                    ST1: if (valid) begin
                        r1_nx  = step_out;
                        fsm_nx = ST2;
                    end
                    ST2: if (valid) begin
                        r2_nx  = step_out;
                        fsm_nx = ST3;
                    end
                    ST3: fsm_nx = ST0;
                    default: fsm_nx = ST0;
                endcase
            end
        end

        // state and byte registers
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                fsm <= ST0;
                r0  <= 8'h00;
                r1  <= 8'h00;
                r2  <= 8'h00;
            end else begin
                fsm <= fsm_nx;
                r0  <= r0_nx;
                r1  <= r1_nx;
                r2  <= r2_nx;
            end
        end
    end

endmodule

// File: tb/tb_xc_aessub.sv
// tb_xc_aessub: directed checks of both xc_aessub variants
// against hand vectors and an independently generated S-box table.
module tb_xc_aessub;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_data;
    logic        valid;
    logic [31:0] rs1, rs2;
    logic        enc;
    logic        rdy_f, rdy_s;
    logic [31:0] res_f, res_s;

    int errors = 0;
    int checks = 0;

    logic [7:0] sbox_m [256];
    logic [7:0] inv_m  [256];

    xc_aessub #(.FAST(1'b1)) u_fast (
        .clock(clock), .reset(reset), .flush(flush),
        .flush_data(flush_data), .valid(valid),
        .rs1(rs1), .rs2(rs2), .enc(enc),
        .ready(rdy_f), .result(res_f)
    );

    xc_aessub #(.FAST(1'b0)) u_slow (
        .clock(clock), .reset(reset), .flush(flush),
        .flush_data(flush_data), .valid(valid),
        .rs1(rs1), .rs2(rs2), .enc(enc),
        .ready(rdy_s), .result(res_s)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic adv;
        @(posedge clock);
        #1;
    endtask

    // One 4-cycle slow op with valid held; fast unit checked in cycle 1
    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic e,
                          input logic [31:0] exp, input bit idle);
        rs1 = a;
        rs2 = b;
        enc = e;
        valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (k == 1) begin
                chk({tag, " fast_rdy"}, {31'b0, rdy_f}, 32'd1);
                chk({tag, " fast_res"}, res_f, exp);
            end
            chk({tag, " slow_rdy"}, {31'b0, rdy_s}, {31'b0, k == 4});
            chk({tag, " slow_res"}, res_s, (k == 4) ? exp : 32'h0);
            adv();
        end
        if (idle) begin
            valid = 1'b0;
            @(negedge clock);
            chk({tag, " idle_rdy"}, {30'b0, rdy_s, rdy_f}, 32'd0);
            chk({tag, " idle_res"}, res_s | res_f, 32'h0);
            adv();
        end
    endtask

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // table generation by walking generator 3 and its inverse
    task automatic build_model;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sbox_m[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_m[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_m[sbox_m[i]] = 8'(i);
    endtask

    initial begin
        logic [7:0] w [4];
        logic [31:0] e;
        build_model();

        reset = 1'b0;
        flush = 1'b0;
        flush_data = 32'h0;
        valid = 1'b1;
        enc = 1'b1;
        rs1 = 32'h0000_0100;
        rs2 = 32'hFF53_0000;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_rdy", {31'b0, rdy_s}, 32'd0);
        chk("rst_res", res_s, 32'h0);
        chk("rst_fsm", {30'b0, u_slow.fsm}, 32'd0);
        valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rel_fsm", {30'b0, u_slow.fsm}, 32'd0);
        chk("idle_fast_res", res_f, 32'h0);
        adv();

        run_op("enc", 32'h0000_0100, 32'hFF53_0000, 1'b1,
               32'h16ED_7C63, 1'b1);
        run_op("dec", 32'h0000_7C63, 32'h16ED_0000, 1'b0,
               32'hFF53_0100, 1'b1);

        // stall at fsm=2 for three cycles
        rs1 = 32'h0000_0100;
        rs2 = 32'hFF53_0000;
        enc = 1'b1;
        valid = 1'b1;
        adv();
        adv();
        valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("stall_rdy", {31'b0, rdy_s}, 32'd0);
            chk("stall_fsm", {30'b0, u_slow.fsm}, 32'd2);
            adv();
        end
        valid = 1'b1;
        @(negedge clock);
        chk("resume1_rdy", {31'b0, rdy_s}, 32'd0);
        adv();
        @(negedge clock);
        chk("resume2_rdy", {31'b0, rdy_s}, 32'd1);
        chk("resume2_res", res_s, 32'h16ED_7C63);
        adv();
        valid = 1'b0;
        adv();

        // flush at fsm=2 with a same-cycle valid
        valid = 1'b1;
        adv();
        adv();
        flush = 1'b1;
        flush_data = 32'hAABB_CCDD;
        @(negedge clock);
        chk("flush_rdy", {31'b0, rdy_s}, 32'd0);
        adv();
        flush = 1'b0;
        valid = 1'b0;
        #1;
        chk("flush_fsm", {30'b0, u_slow.fsm}, 32'd0);
        chk("flush_regs", {8'h0, u_slow.r2, u_slow.r1, u_slow.r0},
            32'h00BB_CCDD);
        run_op("post_flush", 32'h0000_0100, 32'hFF53_0000, 1'b1,
               32'h16ED_7C63, 1'b1);

        // back-to-back ops, ready in cycles 4 and 8
        run_op("b2b_a", 32'h0000_0100, 32'hFF53_0000, 1'b1,
               32'h16ED_7C63, 1'b0);
        run_op("b2b_b", 32'h0000_7C63, 32'h16ED_0000, 1'b0,
               32'hFF53_0100, 1'b1);

        // exhaustive forward then inverse over all bytes
        for (int j = 0; j < 64; j++) begin
            for (int i = 0; i < 4; i++) w[i] = 8'(4 * j + i);
            e = {sbox_m[w[3]], sbox_m[w[2]], sbox_m[w[1]], sbox_m[w[0]]};
            run_op("exh_enc", {16'h0, w[1], w[0]}, {w[3], w[2], 16'h0},
                   1'b1, e, 1'b0);
        end
        for (int j = 0; j < 64; j++) begin
            for (int i = 0; i < 4; i++) w[i] = sbox_m[4 * j + i];
            e = {inv_m[w[3]], inv_m[w[2]], inv_m[w[1]], inv_m[w[0]]};
            run_op("exh_dec", {16'h0, w[1], w[0]}, {w[3], w[2], 16'h0},
                   1'b0, e, j == 63);
        end

        // reset mid-operation abandons without a ready pulse
        valid = 1'b1;
        enc = 1'b1;
        rs1 = 32'h0000_0100;
        rs2 = 32'hFF53_0000;
        adv();
        adv();
        reset = 1'b0;
        #1;
        chk("midrst_fsm", {30'b0, u_slow.fsm}, 32'd0);
        chk("midrst_rdy", {31'b0, rdy_s}, 32'd0);
        adv();
        reset = 1'b1;
        valid = 1'b0;
        adv();
        run_op("reissue", 32'h0000_0100, 32'hFF53_0000, 1'b1,
               32'h16ED_7C63, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
